// File: rtl/ram16_fifo_ctrl.sv
// Address/flag controller for a 16-deep FIFO built on an external 16x1
// dual-port distributed RAM bank. The controller owns the write pointer
// (RAM A3..A0 / WE) and the read pointer (RAM DPRA3..DPRA0). The data words
// never pass through this block: the producer drives RAM D and the consumer
// reads RAM DPO directly.
module ram16_fifo_ctrl #(
    parameter int unsigned AFULL_LVL = 12
) (
    input  logic       WCLK,
    input  logic       RST_N,
    input  logic       FLUSH,
    input  logic       PUSH_VALID,
    output logic       PUSH_READY,
    output logic       POP_VALID,
    input  logic       POP_READY,
    output logic [3:0] WADDR,
    output logic       WEN,
    output logic [3:0] RADDR,
    output logic [4:0] COUNT,
    output logic       FULL,
    output logic       EMPTY,
    output logic       AFULL,
    output logic [4:0] HWM
);

    logic [3:0] wp_q, wp_d;
    logic [3:0] rp_q, rp_d;
    logic [4:0] count_q, count_d;
    logic [4:0] hwm_q, hwm_d;

    logic full, empty;
    logic push, pop;

    // Flags come straight from the registered count, so POP_READY never
    // reaches PUSH_READY combinationally.
    assign full  = (count_q == 5'd16);
    assign empty = (count_q == 5'd0);

    assign FULL       = full;
    assign EMPTY      = empty;
    assign AFULL      = (count_q >= 5'(AFULL_LVL));
    assign COUNT      = count_q;
    assign HWM        = hwm_q;
    assign WADDR      = wp_q;
    assign RADDR      = rp_q;
    assign POP_VALID  = ~empty;

    // A full queue refuses pushes even when a pop frees a slot this cycle.
    assign PUSH_READY = ~full & ~FLUSH;
    assign WEN        = PUSH_VALID & PUSH_READY;

    assign push = WEN;
    assign pop  = ~empty & POP_READY & ~FLUSH;

    // Next-state for pointers, occupancy and high-water mark; FLUSH wins.
    always_comb begin
        wp_d    = wp_q;
        rp_d    = rp_q;
        count_d = count_q;
        hwm_d   = hwm_q;
        if (FLUSH) begin
            wp_d    = 4'd0;
            rp_d    = 4'd0;
            count_d = 5'd0;
            hwm_d   = 5'd0;
        end else begin
            // 4-bit pointers wrap 15->0 naturally; wp==rp is disambiguated
            // by count alone.
            if (push) wp_d = wp_q + 4'd1;
            if (pop)  rp_d = rp_q + 4'd1;
            case ({push, pop})
                2'b10:   count_d = count_q + 5'd1;
                2'b01:   count_d = count_q - 5'd1;
                default: count_d = count_q;
            endcase
            if (count_d > hwm_q) hwm_d = count_d;
        end
    end

    // State registers; reset clears the queue immediately, without a clock.
    always_ff @(posedge WCLK or negedge RST_N) begin
        if (!RST_N) begin
            wp_q    <= 4'd0;
            rp_q    <= 4'd0;
            count_q <= 5'd0;
            hwm_q   <= 5'd0;
        end else begin
            wp_q    <= wp_d;
            rp_q    <= rp_d;
            count_q <= count_d;
            hwm_q   <= hwm_d;
        end
    end

endmodule

// File: tb/tb_ram16_fifo_ctrl.sv
// Directed bench for ram16_fifo_ctrl with a behavioural model of the
// external 16-entry dual-port RAM attached to WADDR/WEN/RADDR.
module tb_ram16_fifo_ctrl;

    logic       WCLK = 1'b0;
    logic       RST_N = 1'b0;
    logic       FLUSH = 1'b0;
    logic       PUSH_VALID = 1'b0;
    logic       PUSH_READY;
    logic       POP_VALID;
    logic       POP_READY = 1'b0;
    logic [3:0] WADDR;
    logic       WEN;
    logic [3:0] RADDR;
    logic [4:0] COUNT;
    logic       FULL, EMPTY, AFULL;
    logic [4:0] HWM;

    logic [7:0] din = 8'd0;
    logic [7:0] mem [16];
    logic [7:0] dpo;

    int total = 0;
    int bad = 0;

    ram16_fifo_ctrl #(.AFULL_LVL(12)) dut (
        .WCLK(WCLK), .RST_N(RST_N), .FLUSH(FLUSH),
        .PUSH_VALID(PUSH_VALID), .PUSH_READY(PUSH_READY),
        .POP_VALID(POP_VALID), .POP_READY(POP_READY),
        .WADDR(WADDR), .WEN(WEN), .RADDR(RADDR),
        .COUNT(COUNT), .FULL(FULL), .EMPTY(EMPTY), .AFULL(AFULL), .HWM(HWM)
    );

    always #5 WCLK = ~WCLK;

    // External RAM: synchronous write at WADDR, asynchronous read at RADDR
    always @(posedge WCLK) if (WEN) mem[WADDR] <= din;
    assign dpo = mem[RADDR];

    initial begin
        #200000;
        $display("FAIL watchdog obs=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s obs=%0d exp=%0d", tag, obs, exp);
        end
    endtask

    // advance one clock edge and settle
    task automatic cyc();
        @(posedge WCLK);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 8'hFF;

        // ---- reset state ----
        #2;
        chk("rst_count", 32'(COUNT), 0);
        chk("rst_empty", 32'(EMPTY), 1);
        chk("rst_full", 32'(FULL), 0);
        chk("rst_afull", 32'(AFULL), 0);
        chk("rst_popv", 32'(POP_VALID), 0);
        chk("rst_hwm", 32'(HWM), 0);
        chk("rst_waddr", 32'(WADDR), 0);
        chk("rst_raddr", 32'(RADDR), 0);
        chk("rst_pushr", 32'(PUSH_READY), 1);
        PUSH_VALID = 1'b1;
        #1;
        chk("rst_wen", 32'(WEN), 1);
        cyc();  // push on an edge while held in reset is lost
        chk("rst_push_lost", 32'(COUNT), 0);
        chk("rst_push_lost_wp", 32'(WADDR), 0);
        PUSH_VALID = 1'b0;
        RST_N = 1'b1;
        $display("reset: count=%0d empty=%0d", COUNT, EMPTY);

        // ---- fill 16 words ----
        for (int i = 0; i < 16; i++) begin
            din = 8'(i);
            PUSH_VALID = 1'b1;
            #1;
            chk("fill_pushr", 32'(PUSH_READY), 1);
            chk("fill_wen", 32'(WEN), 1);
            cyc();
            chk("fill_count", 32'(COUNT), 32'(i + 1));
            chk("fill_afull", 32'(AFULL), 32'((i + 1) >= 12));
            chk("fill_full", 32'(FULL), 32'((i + 1) == 16));
            chk("fill_popv", 32'(POP_VALID), 1);
            $display("push %0d: count=%0d afull=%0d full=%0d", i, COUNT, AFULL, FULL);
        end
        chk("full_pushr", 32'(PUSH_READY), 0);
        chk("full_wen", 32'(WEN), 0);
        chk("full_hwm", 32'(HWM), 16);
        cyc();  // refused push leaves state alone
        chk("full_hold_count", 32'(COUNT), 16);
        chk("full_hold_waddr", 32'(WADDR), 0);
        PUSH_VALID = 1'b0;

        // ---- drain ----
        POP_READY = 1'b1;
        for (int i = 0; i < 16; i++) begin
            #1;
            chk("drain_popv", 32'(POP_VALID), 1);
            chk("drain_data", 32'(dpo), 32'(i));
            $display("pop %0d: data=%0d", i, dpo);
            cyc();
            chk("drain_count", 32'(COUNT), 32'(15 - i));
        end
        chk("drain_empty", 32'(EMPTY), 1);
        chk("drain_raddr", 32'(RADDR), 0);
        chk("drain_hwm", 32'(HWM), 16);
        cyc();  // pop on empty does nothing
        chk("empty_pop_count", 32'(COUNT), 0);
        chk("empty_pop_raddr", 32'(RADDR), 0);
        POP_READY = 1'b0;

        // ---- simultaneous push/pop at COUNT=5 ----
        PUSH_VALID = 1'b1;
        for (int i = 0; i < 5; i++) begin
            din = 8'(100 + i);
            cyc();
        end
        chk("sim_pre_count", 32'(COUNT), 5);
        POP_READY = 1'b1;
        for (int k = 0; k < 20; k++) begin
            din = 8'(105 + k);
            #1;
            chk("sim_data", 32'(dpo), 32'(100 + k));
            cyc();
            chk("sim_count", 32'(COUNT), 5);
            $display("sim %0d: data=%0d count=%0d", k, 100 + k, COUNT);
        end
        chk("sim_waddr", 32'(WADDR), 9);
        chk("sim_raddr", 32'(RADDR), 4);
        chk("sim_next_data", 32'(dpo), 120);

        // ---- full boundary ----
        POP_READY = 1'b0;
        for (int i = 0; i < 11; i++) begin
            din = 8'(200 + i);
            cyc();
        end
        chk("bnd_count16", 32'(COUNT), 16);
        POP_READY = 1'b1;
        #1;
        chk("bnd_pushr", 32'(PUSH_READY), 0);
        chk("bnd_wen", 32'(WEN), 0);
        cyc();
        chk("bnd_count15", 32'(COUNT), 15);
        POP_READY = 1'b0;
        #1;
        chk("bnd_pushr2", 32'(PUSH_READY), 1);
        cyc();
        chk("bnd_count16b", 32'(COUNT), 16);
        $display("boundary: count=%0d full=%0d", COUNT, FULL);

        // ---- flush at COUNT=9 ----
        PUSH_VALID = 1'b0;
        POP_READY = 1'b1;
        for (int i = 0; i < 7; i++) cyc();
        POP_READY = 1'b0;
        chk("fl_pre_count", 32'(COUNT), 9);
        FLUSH = 1'b1;
        PUSH_VALID = 1'b1;
        #1;
        chk("fl_wen", 32'(WEN), 0);
        chk("fl_pushr", 32'(PUSH_READY), 0);
        cyc();
        chk("fl_count", 32'(COUNT), 0);
        chk("fl_hwm", 32'(HWM), 0);
        chk("fl_waddr", 32'(WADDR), 0);
        chk("fl_raddr", 32'(RADDR), 0);
        chk("fl_empty", 32'(EMPTY), 1);
        FLUSH = 1'b0;
        $display("flush: count=%0d hwm=%0d", COUNT, HWM);

        // ---- async reset at COUNT=7 ----
        for (int i = 0; i < 7; i++) cyc();
        PUSH_VALID = 1'b0;
        chk("ar_pre_count", 32'(COUNT), 7);
        chk("ar_pre_hwm", 32'(HWM), 7);
        #2;
        RST_N = 1'b0;
        #1;
        chk("ar_count", 32'(COUNT), 0);
        chk("ar_empty", 32'(EMPTY), 1);
        chk("ar_hwm", 32'(HWM), 0);
        chk("ar_waddr", 32'(WADDR), 0);
        #1;
        RST_N = 1'b1;
        $display("async reset: count=%0d empty=%0d", COUNT, EMPTY);

        // ---- first push after reset on first edge ----
        PUSH_VALID = 1'b1;
        din = 8'd42;
        cyc();
        PUSH_VALID = 1'b0;
        chk("post_count", 32'(COUNT), 1);
        chk("post_popv", 32'(POP_VALID), 1);
        #1;
        chk("post_data", 32'(dpo), 42);
        $display("post-reset push: count=%0d data=%0d", COUNT, dpo);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ram16_fifo_ctrl.md
RAM16_FIFO_CTRL -- requirements
Module: ram16_fifo_ctrl

Interface
REQ-001 The block SHALL have parameter AFULL_LVL, default 12: COUNT level (1..16) at or above which AFULL asserts.
REQ-002 The block SHALL have port WCLK, input, 1 bit: the single clock; all state updates on its rising edge; also drives WCLK of the external 16x1 dual-port RAM bank.
REQ-003 The block SHALL have port RST_N, input, 1 bit: asynchronous active-low reset.
REQ-004 The block SHALL have port FLUSH, input, 1 bit: synchronous clear of the queue.
REQ-005 The block SHALL have port PUSH_VALID, input, 1 bit: the producer offers a word on the RAM D inputs.
REQ-006 The block SHALL have port PUSH_READY, output, 1 bit: a push is accepted this cycle.
REQ-007 The block SHALL have port POP_VALID, output, 1 bit: RAM DPO outputs hold the head word.
REQ-008 The block SHALL have port POP_READY, input, 1 bit: the consumer takes the head word.
REQ-009 The block SHALL have port WADDR, output, 4 bits: drives the RAM write/SPO address pins A3..A0.
REQ-010 The block SHALL have port WEN, output, 1 bit: drives the RAM WE pin.
REQ-011 The block SHALL have port RADDR, output, 4 bits: drives the RAM read address pins DPRA3..DPRA0.
REQ-012 The block SHALL have port COUNT, output, 5 bits: occupancy, 0..16.
REQ-013 The block SHALL have ports FULL, EMPTY and AFULL, outputs, 1 bit each: occupancy flags.
REQ-014 The block SHALL have port HWM, output, 5 bits: high-water mark, the maximum COUNT reached since reset or FLUSH.

Function
REQ-015 The block SHALL hold a 4-bit write pointer wp, a 4-bit read pointer rp and a 5-bit count; WADDR=wp and RADDR=rp.
REQ-016 The block SHALL drive FULL=(count==16), EMPTY=(count==0) and AFULL=(count>=AFULL_LVL), all decoded from registered count.
REQ-017 The block SHALL drive PUSH_READY = ~FULL & ~FLUSH, with no combinational path from POP_READY.
REQ-018 The block SHALL drive WEN = PUSH_VALID & PUSH_READY, combinationally.
REQ-019 On a push, wp SHALL increment modulo 16 at the clock edge; the RAM captures D at address wp on that same edge.
REQ-020 The block SHALL drive POP_VALID = ~EMPTY; a pop occurs when POP_VALID & POP_READY & ~FLUSH, and then rp increments modulo 16.
REQ-021 Count SHALL be +1 on push only, -1 on pop only, and unchanged on simultaneous push+pop or on neither.
REQ-022 When the queue is full, a push in the same cycle as a pop SHALL NOT be accepted (PUSH_READY=0).
REQ-023 When the queue is empty, no pop SHALL occur; a word pushed into an empty queue SHALL give POP_VALID=1 one cycle after the push edge (latency 1).
REQ-024 Pointer wrap 15->0 SHALL be seamless; wp==rp is resolved by count alone.
REQ-025 FLUSH SHALL set wp, rp, count and HWM to 0 on the next edge, overriding any push or pop that cycle; RAM contents are not cleared.
REQ-026 HWM SHALL update to the next count value whenever that value exceeds the current HWM.
REQ-027 PUSH_VALID while PUSH_READY=0 SHALL have no effect on state.

Reset
REQ-028 When RST_N=0, wp, rp, count and HWM SHALL clear to 0 immediately, independent of WCLK.
REQ-029 Outputs during and after reset SHALL be: EMPTY=1, FULL=0, AFULL=0, POP_VALID=0, COUNT=0, HWM=0, WADDR=0, RADDR=0, PUSH_READY=~FLUSH, WEN=PUSH_VALID&~FLUSH.
REQ-030 Reset asserted mid-operation SHALL abandon the queue contents logically; a push on the edge where RST_N is low SHALL be lost.
REQ-031 The first push after RST_N deasserts SHALL be accepted on the first rising edge of WCLK.

Verification
REQ-032 Fill: 16 back-to-back pushes of words 0..15, POP_READY=0 -> COUNT=16, FULL=1, PUSH_READY=0, AFULL high from COUNT=12, HWM=16.
REQ-033 Drain: starting from the fill state, POP_READY=1 for 16 cycles -> DPO yields 0..15 in order, then EMPTY=1, RADDR=0, HWM stays 16.
REQ-034 Simultaneous: COUNT=5, push and pop together for 20 cycles -> COUNT stays 5, both pointers wrap past 15, data order preserved.
REQ-035 Full boundary: COUNT=16, PUSH_VALID=1 and POP_READY=1 -> pop taken, push refused, COUNT=15; next cycle push accepted, COUNT=16.
REQ-036 Flush and reset: COUNT=9 with FLUSH=1 and PUSH_VALID=1 -> next edge COUNT=0, HWM=0, WEN=0; RST_N pulsed low between clock edges at COUNT=7 -> COUNT=0 and EMPTY=1 immediately.
